// File: rtl/mem_port_pkg.sv
// Shared types and defaults for the memory-port master and its wait counter.
// The FSM encoding is fixed at two bits so it can be probed directly on the bus.
package mem_port_pkg;

   localparam int WORDSIZE_DEF = 16;
   localparam int ADDRSIZE_DEF = 8;
   localparam int WAIT_CNT_W   = 4;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ACCESS = 2'd1;
   localparam logic [1:0] ST_RESP   = 2'd2;

   typedef enum logic [1:0] {
      IDLE   = ST_IDLE,
      ACCESS = ST_ACCESS,
      RESP   = ST_RESP
   } state_e;

endpackage

// File: rtl/mem_wait_counter.sv
// Loadable down-counter that times how long an access is held on the memory bus.
// zero_o marks the final bus cycle; one_o marks the cycle just before it.
module mem_wait_counter
   import mem_port_pkg::*;
#(
   parameter int W = WAIT_CNT_W
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         dec_i,
   output logic         zero_o,
   output logic         one_o
);

   logic [W-1:0] cnt_q, cnt_d;

   // NOTE: every variable written here gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - W'(1);
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero_o = (cnt_q == '0);
   assign one_o  = (cnt_q == W'(1));

endmodule

// File: rtl/mem_port_master.sv
// Initiator for the single-port word memory: one load/store at a time over valid/ready.
// Define ALIGN_CHECK_EN to reject odd byte addresses with rsp_err instead of issuing them.
module mem_port_master
   import mem_port_pkg::*;
#(
   parameter int wordsize    = WORDSIZE_DEF,
   parameter int addrsize    = ADDRSIZE_DEF,
   parameter int WAIT_STATES = 0
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_we,
   input  logic [addrsize-1:0] req_addr,
   input  logic [wordsize-1:0] req_wdata,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [wordsize-1:0] rsp_rdata,
   output logic                rsp_err,
   output logic [addrsize-1:0] mem_addr,
   output logic [wordsize-1:0] mem_wdata,
   input  logic [wordsize-1:0] mem_rdata,
   output logic                mem_rw
);

   localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = WAIT_CNT_W'(WAIT_STATES);
   // With no wait states the first ACCESS cycle is also the last, so a store writes immediately.
   localparam logic WRITE_ON_ACCEPT = (WAIT_STATES == 0);

   state_e              state_q, state_d;
   logic                we_q, we_d;
   logic [addrsize-1:0] mem_addr_q, mem_addr_d;
   logic [wordsize-1:0] mem_wdata_q, mem_wdata_d;
   logic [wordsize-1:0] rsp_rdata_q, rsp_rdata_d;
   logic                rsp_err_q, rsp_err_d;
   logic                mem_rw_q, mem_rw_d;
   logic                cnt_load, cnt_dec, cnt_zero, cnt_one;
   logic                misaligned;

`ifdef ALIGN_CHECK_EN
   assign misaligned = req_addr[0];
`else
   assign misaligned = 1'b0;
`endif

   mem_wait_counter #(
      .W (WAIT_CNT_W)
   ) u_wait_cnt (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_i     (cnt_load),
      .load_val_i (WAIT_LOAD),
      .dec_i      (cnt_dec),
      .zero_o     (cnt_zero),
      .one_o      (cnt_one)
   );

   always_comb begin
      state_d     = state_q;
      we_d        = we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
      mem_rw_d    = 1'b0;
      cnt_load    = 1'b0;
      cnt_dec     = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (req_valid) begin
               if (misaligned) begin
                  state_d     = RESP;
                  rsp_rdata_d = '0;
                  rsp_err_d   = 1'b1;
               end else begin
                  state_d     = ACCESS;
                  we_d        = req_we;
                  mem_addr_d  = req_addr;
                  mem_wdata_d = req_wdata;
                  cnt_load    = 1'b1;
                  mem_rw_d    = req_we && WRITE_ON_ACCEPT;
               end
            end
         end
         ACCESS: begin
            if (cnt_zero) begin
               state_d     = RESP;
               rsp_rdata_d = we_q ? '0 : mem_rdata;
               rsp_err_d   = 1'b0;
            end else begin
               cnt_dec  = 1'b1;
               // Raise rw for the cycle in which the counter will read zero: exactly one write edge.
               mem_rw_d = we_q && cnt_one;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // mem_rw is cleared asynchronously so a reset during a store's last cycle prevents the commit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         we_q        <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
         mem_rw_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         we_q        <= we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
         mem_rw_q    <= mem_rw_d;
      end
   end

   assign req_ready = (state_q == IDLE);
   assign rsp_valid = (state_q == RESP);
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_rw    = mem_rw_q;

endmodule

// File: tb/tb_mem_port_master.sv
// Self-checking bench for mem_port_master with a word memory model and a timestamp-based reference.
// Honours ALIGN_CHECK_EN the same way as the design.
`timescale 1ns/1ps
module tb_mem_port_master;

   localparam int WS = 3;
`ifdef ALIGN_CHECK_EN
   localparam bit ALIGN = 1'b1;
`else
   localparam bit ALIGN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid, req_we;
   logic [7:0]  req_addr;
   logic [15:0] req_wdata;
   logic        rsp_ready = 1'b1;
   logic        req_ready, rsp_valid, rsp_err, mem_rw;
   logic [15:0] rsp_rdata, mem_wdata, mem_rdata;
   logic [7:0]  mem_addr;

   int n_checks = 0;
   int n_pass   = 0;
   int rdy_mode = 1;   // 0: hold rsp_ready low, 1: always ready, 2: random
   int rw_cnt   = 0;

   always #5 clk = ~clk;

   mem_port_master #(
      .wordsize    (16),
      .addrsize    (8),
      .WAIT_STATES (WS)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_rw    (mem_rw)
   );

   function automatic logic [15:0] init_word(input int i);
      return 16'(i * 16'h0307) ^ 16'hA5A5;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   // Word memory: synchronous write, combinational read; data_out floats while rw=1 (shown as DEAD).
   logic [15:0] mem [128];
   assign mem_rdata = mem_rw ? 16'hDEAD : mem[mem_addr[7:1]];
   initial begin
      for (int i = 0; i < 128; i++) mem[i] = init_word(i);
      forever begin
         @(posedge clk);
         if (mem_rw) mem[mem_addr[7:1]] <= mem_wdata;
      end
   end

   initial forever begin
      @(negedge clk);
      if (mem_rw === 1'b1) rw_cnt++;
   end

   initial forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
         0:       rsp_ready = 1'b0;
         1:       rsp_ready = 1'b1;
         default: rsp_ready = ($urandom_range(0, 3) != 0);
      endcase
   end

   // Reference: an accepted request at the edge starting cycle c answers from cycle t_rsp = c+WS+1
   // (or c for a rejected odd address); a store's write cycle is t_rsp-1.
   logic [15:0] ref_mem [128];
   int unsigned cyc = 0;
   int unsigned t_rsp = 0;
   bit          m_busy = 1'b0, m_we = 1'b0, m_bad = 1'b0;
   logic [7:0]  m_addr = '0, e_mem_addr = '0;
   logic [15:0] m_wdata = '0, e_mem_wdata = '0, e_rdata = '0;
   bit          e_err = 1'b0;

   initial begin
      for (int i = 0; i < 128; i++) ref_mem[i] = init_word(i);
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            m_busy = 0; e_mem_addr = '0; e_mem_wdata = '0; e_rdata = '0; e_err = 0;
         end else begin
            cyc++;
            if (m_busy) begin
               if ((cyc - 1 >= t_rsp) && rsp_ready) m_busy = 0;
            end else if (req_valid) begin
               m_busy = 1; m_we = req_we; m_addr = req_addr; m_wdata = req_wdata;
               m_bad  = ALIGN && req_addr[0];
               if (m_bad) t_rsp = cyc;
               else begin
                  t_rsp = cyc + WS + 1;
                  e_mem_addr = req_addr; e_mem_wdata = req_wdata;
               end
            end
            if (m_busy && cyc == t_rsp) begin
               e_err   = m_bad;
               e_rdata = (m_bad || m_we) ? 16'h0 : ref_mem[m_addr[7:1]];
               if (!m_bad && m_we) ref_mem[m_addr[7:1]] = m_wdata;
            end
         end
      end
   end

   initial forever begin
      @(negedge clk);
      begin
         bit exp_rv;
         exp_rv = m_busy && (cyc >= t_rsp);
         check("req_ready", req_ready, !m_busy);
         check("rsp_valid", rsp_valid, exp_rv);
         check("mem_rw", mem_rw, m_busy && m_we && !m_bad && (cyc + 1 == t_rsp));
         check("mem_addr", mem_addr, e_mem_addr);
         check("mem_wdata", mem_wdata, e_mem_wdata);
         if (exp_rv || !rst_n) begin
            check("rsp_rdata", rsp_rdata, e_rdata);
            check("rsp_err", rsp_err, e_err);
         end
      end
   end

   // Present a request and hold it until the handshake edge; returns at +1 after that edge.
   task automatic issue(input logic we, input logic [7:0] addr, input logic [15:0] wdata,
                        output int unsigned hs_cyc);
      int n = 0;
      req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
      while (!req_ready && n < 200) begin
         @(posedge clk); #1; n++;
      end
      if (n == 200) check("accept_timeout", 0, 1);
      @(posedge clk); #1;
      hs_cyc    = cyc;
      req_valid = 1'b0;
   endtask

   // Count edges (handshake edge = 1) until rsp_valid; also count cycles mem_addr left exp_addr.
   task automatic wait_rsp(input logic [7:0] exp_addr, output int edges,
                           output logic [15:0] rdata, output logic err, output int addr_moves);
      edges = 1; addr_moves = 0;
      while (!rsp_valid && edges < 200) begin
         if (mem_addr !== exp_addr) addr_moves++;
         @(posedge clk); #1; edges++;
      end
      if (edges == 200) check("rsp_timeout", 0, 1);
      rdata = rsp_rdata; err = rsp_err;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int unsigned hs, hs_prev;
      int          edges, moves, rw0;
      logic [15:0] rd;
      logic        er;
      logic [7:0]  b2b_addr [4];

      rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_req_ready", req_ready, 1);
      check("reset_rsp_valid", rsp_valid, 0);
      check("reset_rsp_rdata", rsp_rdata, 0);
      check("reset_rsp_err", rsp_err, 0);
      check("reset_mem_rw", mem_rw, 0);
      check("reset_mem_addr", mem_addr, 0);
      check("reset_mem_wdata", mem_wdata, 0);
      @(posedge clk); #2 rst_n = 1'b1;
      @(posedge clk); #1;

      // Store then load the same word; store pulses rw for one cycle.
      rw0 = rw_cnt;
      issue(1'b1, 8'h10, 16'hBEEF, hs);
      wait_rsp(8'h10, edges, rd, er, moves);
      check("store_latency", edges, 5);
      check("store_rdata_zero", rd, 16'h0000);
      check("store_err", er, 0);
      check("store_rw_cycles", rw_cnt - rw0, 1);
      issue(1'b0, 8'h10, 16'h0000, hs);
      wait_rsp(8'h10, edges, rd, er, moves);
      check("load_beef", rd, 16'hBEEF);
      check("load_err", er, 0);

      issue(1'b1, 8'h20, 16'h5A5A, hs);
      wait_rsp(8'h20, edges, rd, er, moves);

      // Load from 0x00: five edges to response, address steady through all access cycles.
      issue(1'b0, 8'h00, 16'h0000, hs);
      wait_rsp(8'h00, edges, rd, er, moves);
      check("load0_latency", edges, 5);
      check("load0_addr_stable", moves, 0);
      check("load0_rdata", rd, 16'hA5A5);

      // Consumer stalls: response holds, a second request is refused.
      rdy_mode = 0;
      issue(1'b0, 8'h10, 16'h0000, hs);
      wait_rsp(8'h10, edges, rd, er, moves);
      req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h00; req_wdata = '0;
      repeat (10) begin
         check("stall_rsp_valid", rsp_valid, 1);
         check("stall_rsp_rdata", rsp_rdata, 16'hBEEF);
         check("stall_req_ready", req_ready, 0);
         @(posedge clk); #1;
      end
      rdy_mode = 1;
      issue(1'b0, 8'h00, 16'h0000, hs);
      wait_rsp(8'h00, edges, rd, er, moves);
      check("after_stall_rdata", rd, 16'hA5A5);

      // Reset in the final access cycle of a store: no write commits.
      issue(1'b1, 8'h20, 16'h1234, hs);
      repeat (WS) @(posedge clk);
      #1;
      check("rw_before_reset", mem_rw, 1);
      #1 rst_n = 1'b0;
      #1;
      check("rw_after_reset", mem_rw, 0);
      check("ready_after_reset", req_ready, 1);
      @(posedge clk); @(posedge clk); #2 rst_n = 1'b1;
      @(posedge clk); #1;
      issue(1'b0, 8'h20, 16'h0000, hs);
      wait_rsp(8'h20, edges, rd, er, moves);
      check("aborted_store_old", rd, 16'h5A5A);

`ifdef ALIGN_CHECK_EN
      rw0 = rw_cnt;
      issue(1'b1, 8'h11, 16'h7777, hs);
      wait_rsp(8'h20, edges, rd, er, moves);
      check("odd_err", er, 1);
      check("odd_rdata", rd, 16'h0000);
      check("odd_latency", edges, 1);
      check("odd_no_write", rw_cnt - rw0, 0);
      check("odd_addr_kept", moves, 0);
`else
      issue(1'b0, 8'h11, 16'h0000, hs);
      wait_rsp(8'h11, edges, rd, er, moves);
      check("odd_load_word", rd, 16'hBEEF);
      check("odd_err", er, 0);
`endif

      // Back-to-back loads with the consumer always ready: one accept every WS+3 cycles.
      b2b_addr[0] = 8'h00; b2b_addr[1] = 8'h10; b2b_addr[2] = 8'h20; b2b_addr[3] = 8'h30;
      for (int k = 0; k < 4; k++) begin
         issue(1'b0, b2b_addr[k], 16'h0000, hs);
         if (k > 0) check("b2b_interval", hs - hs_prev, 6);
         hs_prev = hs;
      end
      wait_rsp(8'h30, edges, rd, er, moves);

      // Randomised traffic against the reference.
      rdy_mode = 2;
      for (int i = 0; i < 80; i++) begin
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
         end
         issue(1'($urandom_range(0, 1)), 8'($urandom), 16'($urandom), hs);
      end
      rdy_mode = 1;
      begin
         int n = 0;
         while (!(req_ready && !rsp_valid) && n < 200) begin
            @(posedge clk); #1; n++;
         end
         if (n == 200) check("drain_timeout", 0, 1);
      end
      @(posedge clk); #1;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
